// File: rtl/invtranscr.sv
// invtranscr: pipelined inverse skin-tone Cr transform, 4-cycle latency, valid/ready with full backpressure.
// Define INVTRANSCR_ROUND_EN for round-half-up scaling; the default build truncates toward -inf.
module invtranscr #(
  parameter int IN_W = 10,
  parameter int FRAC = 8,
  parameter int IW_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] transcr_in,
  input  logic [7:0]      y_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      cr_out
);
  localparam int PW = IN_W + IW_W + 1;
  localparam int SW = PW + 1;
  // Chroma-cluster model: Ymin=16, Ymax=235, Kl=125, Kh=188, Wcr=38.76 (widths in hundredths)
  function automatic int yclamp(input logic [7:0] y);
    return y < 8'd16 ? 16 : y > 8'd235 ? 235 : int'(y);
  endfunction
  function automatic logic [7:0] meancr(input logic [7:0] y);
    int yc;
    yc = yclamp(y);
    return yc < 125 ? 8'(154 - ((125 - yc) * 10 + 108) / 109) :
           yc > 188 ? 8'(154 + (yc - 188) * 22 / 47) : 8'd154;
  endfunction
  function automatic logic [IW_W-1:0] invwidthcr(input logic [7:0] y);
    int yc, w;
    yc = yclamp(y);
    w = yc < 125 ? 2000 + (yc - 16) * 1876 / 109 : 1000 + (235 - yc) * 2876 / 47;
    return (yc >= 125 && yc <= 188) ? IW_W'(1 << FRAC) : IW_W'(w * (1 << FRAC) / 3876);
  endfunction
  logic                   adv;
  logic                   v1_q, v2_q, v3_q, v4_q, out_valid_q;
  logic [IN_W-1:0]        t1_q, t2_q, t3_q;
  logic [7:0]             y1_q, mean2_q, mean3_q, cr_q;
  logic                   b1_q, b2_q, b3_q, b1_d;
  logic [7:0]             mean2_d, cr_d;
  logic [IW_W-1:0]        invw2_q, invw2_d;
  logic signed [IN_W:0]   d2_q, d2_d;
  logic signed [PW-1:0]   p3_q, p3_d, pr, q;
  logic signed [SW-1:0]   s4_q, s4_d;
  assign adv = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign out_valid = out_valid_q;
  assign cr_out = cr_q;
  always_comb begin
    b1_d = (y_in >= 8'd125) && (y_in <= 8'd188);
    mean2_d = meancr(y1_q);
    invw2_d = invwidthcr(y1_q);
    d2_d = $signed({t1_q[IN_W-1], t1_q}) - (IN_W+1)'(154);
    p3_d = $signed(PW'(d2_q)) * $signed(PW'({1'b0, invw2_q}));
`ifdef INVTRANSCR_ROUND_EN
    pr = p3_q + PW'(1 << (FRAC - 1));
`else
    pr = p3_q;
`endif
    q = pr >>> FRAC;
    s4_d = b3_q ? SW'($signed(t3_q)) : SW'(q) + $signed(SW'({1'b0, mean3_q}));
    cr_d = s4_q < 0 ? 8'd0 : s4_q > 255 ? 8'd255 : s4_q[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, v4_q, out_valid_q} <= '0;
      {t1_q, t2_q, t3_q} <= '0;
      {y1_q, mean2_q, mean3_q, cr_q} <= '0;
      {b1_q, b2_q, b3_q} <= '0;
      invw2_q <= '0;
      d2_q <= '0;
      p3_q <= '0;
      s4_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      t1_q <= transcr_in;
      y1_q <= y_in;
      b1_q <= b1_d;
      v2_q <= v1_q;
      t2_q <= t1_q;
      b2_q <= b1_q;
      mean2_q <= mean2_d;
      invw2_q <= invw2_d;
      d2_q <= d2_d;
      v3_q <= v2_q;
      t3_q <= t2_q;
      b3_q <= b2_q;
      mean3_q <= mean2_q;
      p3_q <= p3_d;
      v4_q <= v3_q;
      s4_q <= s4_d;
      out_valid_q <= v4_q;
      cr_q <= cr_d;
    end
  end
endmodule

// File: tb/tb_invtranscr.sv
// tb_invtranscr: directed vector table plus backpressure and mid-stream reset sequences for invtranscr.
module tb_invtranscr;
  typedef struct {
    logic signed [9:0] tcr;
    logic [7:0]        y;
    logic [7:0]        exp_t;
    logic [7:0]        exp_r;
    string             name;
  } vec_t;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [9:0] transcr_in = '0;
  logic [7:0]        y_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        cr_out;
  int                n_chk = 0;
  int                n_fail = 0;
  vec_t              tbl[14];
  invtranscr dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .transcr_in(transcr_in), .y_in(y_in), .out_valid(out_valid),
    .out_ready(out_ready), .cr_out(cr_out)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pick(input vec_t v);
`ifdef INVTRANSCR_ROUND_EN
    return v.exp_r;
`else
    return v.exp_t;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  task automatic send_and_check(input vec_t v);
    @(negedge clk);
    transcr_in = v.tcr;
    y_in = v.y;
    in_valid = 1'b1;
    #1 chk($sformatf("%s_rdy", v.name), in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk($sformatf("%s_early", v.name), out_valid, 0);
    @(posedge clk);
    #1 chk($sformatf("%s_vld", v.name), out_valid, 1);
    chk(v.name, cr_out, pick(v));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int sent, got, nst, extra;
    logic [7:0] held;
    bit was_st;
    tbl[0]  = '{10'sd200,  8'd150, 8'd200, 8'd200, "byp200"};
    tbl[1]  = '{-10'sd5,   8'd150, 8'd0,   8'd0,   "byp_neg"};
    tbl[2]  = '{10'sd154,  8'd60,  8'd148, 8'd148, "zero_off60"};
    tbl[3]  = '{10'sd511,  8'd0,   8'd255, 8'd255, "sat_hi"};
    tbl[4]  = '{-10'sd512, 8'd0,   8'd0,   8'd0,   "sat_lo"};
    tbl[5]  = '{10'sd186,  8'd0,   8'd160, 8'd161, "round_half"};
    tbl[6]  = '{10'sd200,  8'd60,  8'd180, 8'd181, "y60_cr200"};
    tbl[7]  = '{10'sd250,  8'd200, 8'd236, 8'd237, "y200_cr250"};
    tbl[8]  = '{10'sd60,   8'd200, 8'd82,  8'd83,  "y200_cr60"};
    tbl[9]  = '{10'sd154,  8'd255, 8'd176, 8'd176, "y255_zero"};
    tbl[10] = '{10'sd300,  8'd125, 8'd255, 8'd255, "byp_kl_edge"};
    tbl[11] = '{10'sd77,   8'd188, 8'd77,  8'd77,  "byp_kh_edge"};
    tbl[12] = '{10'sd154,  8'd124, 8'd153, 8'd153, "y124_nobyp"};
    tbl[13] = '{10'sd254,  8'd189, 8'd252, 8'd252, "y189_nobyp"};
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cr_out", cr_out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[i]) send_and_check(tbl[i]);
    @(posedge clk);
    #1;
    sent = 0; got = 0; nst = 0; was_st = 0; held = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      in_valid = sent < 8;
      if (sent < 8) begin
        transcr_in = tbl[sent].tcr;
        y_in = tbl[sent].y;
      end
      #1;
      if (out_valid && !out_ready) begin
        nst++;
        chk("bp_stall_rdy", in_ready, 0);
        if (was_st) chk("bp_hold", cr_out, held);
        held = cr_out;
        was_st = 1;
      end else was_st = 0;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_beat%0d", got), cr_out, pick(tbl[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_count", got, 8);
    chk("bp_sent", sent, 8);
    chk("bp_stalls", nst, 3);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("bp_extra", extra, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      transcr_in = tbl[i].tcr;
      y_in = tbl[i].y;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_vld", out_valid, 1);
    chk("rst_pre_cr", cr_out, 200);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", out_valid, 0);
    chk("rst_mid_cr", cr_out, 0);
    #2 rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("rst_stale", extra, 0);
    send_and_check(tbl[11]);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/invtranscr.md
# invtranscr

Pipelined inverse of the skin-tone nonlinear Cr transform. It takes a transformed chroma sample Cr′ and its luma Y and reconstructs the original 8-bit Cr, saturated to 0..255. It sits on the write-back / debug-visualisation path after the skin classifier, so cluster-space samples can be mapped back to YCbCr. Flow control is a valid/ready stream with full backpressure, and the pipeline has a fixed latency of 4 cycles.

## Interface
Parameters:
- IN_W, 10: width of the signed transformed-Cr input, two's complement.
- FRAC, 8: number of fractional bits in the inverse-width LUT value and in the product.
- IW_W, 12: width of the unsigned Q(IW_W−FRAC).FRAC inverse-width LUT output.

Ports:
- clk, input, 1: the only clock; all state is rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: the input beat is valid.
- in_ready, output, 1: the block accepts a beat on this cycle.
- transcr_in, input, IN_W: transformed Cr′, signed.
- y_in, input, 8: luma Y.
- out_valid, output, 1: the output beat is valid.
- out_ready, input, 1: the downstream block accepts the output beat.
- cr_out, output, 8: reconstructed Cr, unsigned.

## Operation
- A beat is accepted when in_valid and in_ready are both high. A beat is delivered when out_valid and out_ready are both high.
- Global advance: adv = !out_valid || out_ready. All stages shift only when adv is high, and in_ready = adv. A bubble in any stage is carried as valid=0 and shifts like data.
- S1 (register):
  - Capture Cr′ and Y.
  - bypass = (`K_l ≤ Y ≤ `K_h), using the datapath.vh constants 125 and 188.
- S2 (lookup and subtract):
  - mean = meancr(Y), using the existing LUT.
  - invw = invwidthcr(Y), a new LUT in Q4.8 equal to 1/width ratio, with invw = 1.0 when Y is in range.
  - d = Cr′ − `meancr_K_h (154), sign-extended to IN_W+1 bits.
- S3 (multiply): p = d × invw, signed, IN_W+IW_W+1 bits.
- S4 (scale, add, saturate):
  - q = p >>> FRAC.
  - s = q + mean, at full width.
  - cr_out = 0 if s < 0; 255 if s > 255; otherwise s[7:0].
  - If bypass is set: cr_out = Cr′ with the same 0..255 saturation applied.
- The bypass flag travels with the beat through every stage.
- Beat order is preserved exactly. No beat is dropped or duplicated.

## Timing
- Reset values (asynchronous, rst_n low): out_valid=0, cr_out=0, all stage valid bits 0, all data registers 0.
- in_ready is combinational from out_valid and out_ready, so it is 1 out of reset.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+4, provided adv stays high.
- Throughput is 1 beat per cycle while out_ready=1.
- With out_valid=1 and out_ready=0:
  - The whole pipeline freezes and in_ready=0.
  - cr_out and out_valid hold stable until the beat is taken.
- With out_valid=0, the pipeline advances regardless of out_ready, so bubbles collapse.
- Accepting an input and delivering an output on the same cycle is legal and is the steady state.
- If rst_n is asserted mid-stream, all in-flight beats are discarded immediately and out_valid drops in the same cycle (no clock needed). The first beat accepted after release has full 4-cycle latency.
- in_valid is ignored during reset.

## Configuration
- `INVTRANSCR_ROUND_EN`
  - Defined: S4 computes q = (p + (1 << (FRAC−1))) >>> FRAC, i.e. round-half-up.
  - Undefined: plain arithmetic shift, i.e. truncation toward −∞.
- Latency and interface are identical in both builds.

## Test plan
- In-range bypass: Y=150, Cr′=200, out_ready=1. Expect cr_out=200 exactly 4 cycles later. Also Y=150, Cr′=−5 → cr_out=0.
- Zero offset: Y=60, Cr′=154. Then d=0, so expect cr_out = meancr(60) integer part after 4 cycles, identical in both builds.
- Saturation, both directions:
  - Y=0, Cr′=511 → cr_out=255.
  - Y=0, Cr′=−512 → cr_out=0.
- Rounding: choose a Y whose invw gives a p fraction of exactly 0.5 LSB. Expect cr_out one higher with `INVTRANSCR_ROUND_EN` defined than without.
- Backpressure: stream 8 back-to-back beats, drop out_ready for 3 cycles mid-stream. Expect:
  - in_ready low during the stall;
  - cr_out stable while stalled;
  - all 8 results emitted in order, with no loss or duplication.
- Reset mid-operation: pulse rst_n low for half a cycle with 3 beats in flight. Expect:
  - out_valid=0 and cr_out=0 immediately;
  - no stale beats emitted afterwards;
  - the next accepted beat appears 4 cycles after acceptance.
